// File: rtl/jedro_1_regfile_mp.sv
// jedro_1_regfile_mp: multi-read-port register file with pending-write busy bits and a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining JEDRO_1_RF_BYPASS_EN.
module jedro_1_regfile_mp #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_RD_PORTS   = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     rd_data_o,
    output logic [NUM_RD_PORTS-1:0]                rd_busy_o,
    input  logic                                   wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]              wr_addr_i,
    input  logic [DATA_WIDTH-1:0]                  wr_data_i,
    input  logic                                   rsv_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]              rsv_addr_i,
    output logic                                   ready_o
);
    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                r_state;
    logic [REG_ADDR_WIDTH-1:0] r_cnt;
    logic [NUM_REGS-1:0]       r_busy;
    logic [DATA_WIDTH-1:0]     r_mem [NUM_REGS];
    logic                      w_run;
    logic                      w_wr;
    logic                      w_rsv;

    assign w_run   = r_state == S_RUN;
    assign w_wr    = w_run && wr_en_i && wr_addr_i != '0;
    assign w_rsv   = w_run && rsv_en_i && rsv_addr_i != '0;
    assign ready_o = w_run;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_INIT;
            r_cnt   <= REG_ADDR_WIDTH'(1);
            r_busy  <= '0;
        end else if (!w_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == REG_ADDR_WIDTH'(NUM_REGS-1)) r_state <= S_RUN;
        end else begin
            // reservation is applied last so it wins over a same-address write
            if (w_wr) r_busy[wr_addr_i] <= 1'b0;
            if (w_rsv) r_busy[rsv_addr_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!w_run) r_mem[r_cnt] <= '0;
        else if (w_wr) r_mem[wr_addr_i] <= wr_data_i;
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [REG_ADDR_WIDTH-1:0] w_addr;
        logic                      w_valid;
        assign w_addr  = rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign w_valid = w_run && w_addr != '0;
`ifdef JEDRO_1_RF_BYPASS_EN
        logic w_hit;
        assign w_hit = w_wr && wr_addr_i == w_addr;
        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = !w_valid ? '0 : w_hit ? wr_data_i : r_mem[w_addr];
        assign rd_busy_o[k] = w_valid && (w_hit ? (w_rsv && rsv_addr_i == w_addr) : r_busy[w_addr]);
`else
        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = w_valid ? r_mem[w_addr] : '0;
        assign rd_busy_o[k] = w_valid && r_busy[w_addr];
`endif
    end
endmodule

// File: tb/tb_jedro_1_regfile_mp.sv
// tb_jedro_1_regfile_mp: random plus directed traffic against an array-based register file model, scoreboard checked.
module tb_jedro_1_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int NR = 2**AW;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic [NP*AW-1:0] rd_addr_i = '0;
    logic [NP*DW-1:0] rd_data_o;
    logic [NP-1:0]    rd_busy_o;
    logic             wr_en_i = 1'b0;
    logic [AW-1:0]    wr_addr_i = '0;
    logic [DW-1:0]    wr_data_i = '0;
    logic             rsv_en_i = 1'b0;
    logic [AW-1:0]    rsv_addr_i = '0;
    logic             ready_o;

    jedro_1_regfile_mp #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .rd_busy_o(rd_busy_o), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i), .ready_o(ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             rdy;
        logic [NP*DW-1:0] data;
        logic [NP-1:0]    busy;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    vectors = 0;
    int    miscompares = 0;

    logic [DW-1:0] m_mem [NR];
    bit            m_busy [NR];
    bit            m_run;
    int            m_init_left;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_run       = 1'b0;
        m_init_left = NR - 1;
    endtask

    task automatic cyc(input bit rn, input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit re, input int ra, input int a0, input int a1, input string nm);
        exp_t e;
        int   a;
        @(negedge clk_i);
        if (!rn) model_reset();
        rstn_i     = rn;
        wr_en_i    = we;
        wr_addr_i  = AW'(wa);
        wr_data_i  = wd;
        rsv_en_i   = re;
        rsv_addr_i = AW'(ra);
        rd_addr_i  = {AW'(a1), AW'(a0)};
        e.rdy  = m_run;
        e.data = '0;
        e.busy = '0;
        for (int k = 0; k < NP; k++) begin
            a = (k == 0) ? a0 : a1;
            if (m_run && a != 0) begin
`ifdef JEDRO_1_RF_BYPASS_EN
                if (we && wa == a) begin
                    e.data[k*DW +: DW] = wd;
                    e.busy[k]          = re && ra == a;
                end else begin
                    e.data[k*DW +: DW] = m_mem[a];
                    e.busy[k]          = m_busy[a];
                end
`else
                e.data[k*DW +: DW] = m_mem[a];
                e.busy[k]          = m_busy[a];
`endif
            end
        end
        q.push_back(e);
        qn.push_back(nm);
        @(posedge clk_i);
        if (rn) begin
            if (m_run) begin
                if (we && wa != 0) begin
                    m_mem[wa]  = wd;
                    m_busy[wa] = 1'b0;
                end
                if (re && ra != 0) m_busy[ra] = 1'b1;
            end else begin
                m_init_left--;
                if (m_init_left == 0) m_run = 1'b1;
            end
        end
    endtask

    task automatic rd(input int a0, input int a1, input string nm);
        cyc(1'b1, 1'b0, 0, '0, 1'b0, 0, a0, a1, nm);
    endtask

    always @(negedge clk_i) begin
        exp_t  e;
        string nm;
        #2;
        if (q.size() > 0) begin
            e  = q.pop_front();
            nm = qn.pop_front();
            vectors++;
            if (ready_o !== e.rdy || rd_data_o !== e.data || rd_busy_o !== e.busy) begin
                miscompares++;
                $display("FAIL %s: got rdy=%b data=%h busy=%b, want rdy=%b data=%h busy=%b",
                         nm, ready_o, rd_data_o, rd_busy_o, e.rdy, e.data, e.busy);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        cyc(1'b0, 1'b0, 0, '0, 1'b0, 0, 1, 2, "reset");
        cyc(1'b0, 1'b1, 3, 32'h1, 1'b1, 3, 3, 0, "reset_ignored");
        for (int i = 0; i < 34; i++)
            cyc(1'b1, 1'b1, 5, 32'h99, 1'b1, 6, $urandom_range(0, NR-1), $urandom_range(0, NR-1), "init_sweep");
        cyc(1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 5, "wr_x5");
        rd(5, 5, "rd_x5");
        cyc(1'b1, 1'b1, 0, 32'h1234, 1'b0, 0, 0, 5, "wr_x0");
        rd(0, 0, "rd_x0");
        cyc(1'b1, 1'b0, 0, '0, 1'b1, 7, 7, 0, "rsv_x7");
        rd(7, 0, "busy_x7");
        cyc(1'b1, 1'b1, 7, 32'h55, 1'b0, 0, 0, 7, "wr_x7");
        rd(7, 7, "done_x7");
        cyc(1'b1, 1'b1, 9, 32'hA, 1'b1, 9, 9, 0, "wr_rsv_x9");
        rd(9, 9, "rd_x9");
        cyc(1'b1, 1'b1, 10, 32'hB, 1'b1, 11, 10, 11, "wr_rsv_diff");
        rd(10, 11, "rd_x10_x11");
        cyc(1'b1, 1'b1, 3, 32'h11, 1'b0, 0, 0, 0, "wr_x3_prior");
        cyc(1'b1, 1'b1, 3, 32'hCAFE, 1'b0, 0, 3, 3, "bypass_x3");
        cyc(1'b1, 1'b1, 12, 32'hF00D, 1'b1, 12, 12, 0, "bypass_rsv_x12");
        rd(3, 12, "after_bypass");
        cyc(1'b1, 1'b0, 0, '0, 1'b1, 4, 4, 0, "rsv_x4");
        rd(4, 4, "busy_x4");
        cyc(1'b0, 1'b0, 0, '0, 1'b0, 0, 4, 5, "reset_run");
        cyc(1'b0, 1'b0, 0, '0, 1'b0, 0, 4, 5, "reset_hold");
        for (int i = 0; i < 10; i++) rd(4, 5, "reinit");
        cyc(1'b0, 1'b0, 0, '0, 1'b0, 0, 4, 5, "reset_init");
        for (int i = 0; i < 34; i++) rd(4, $urandom_range(0, NR-1), "resweep");
        for (int i = 0; i < 400; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
                1'($urandom_range(0, 1)), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), "random");
        @(negedge clk_i);
        #3;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
